// File: rtl/mem_sequencer.sv
// Multi-cycle fetch/data sequencer letting the RV32 datapath share one single-port memory.
// Optional per-access watchdog built when MEM_SEQ_TIMEOUT_EN is defined.
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] instr,
  output logic [31:0] rdata,
  output logic        step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        fault
);

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StData,
    StWb,
    StHalt
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  state_e      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic        w_unused_pc;

  assign w_is_load   = (r_instr[6:0] == OpLoad);
  assign w_is_store  = (r_instr[6:0] == OpStore);
  assign w_is_mem    = w_is_load | w_is_store;
  assign w_size      = r_instr[13:12];
  assign w_misalign  = ((w_size == 2'b01) && d_addr[0]) ||
                       ((w_size == 2'b10) && (d_addr[1:0] != 2'b00)) ||
                       (w_size == 2'b11);
  assign w_unused_pc = ^pc[1:0];

  // Store lane steering: narrow data replicated across all lanes, enables select the lane.
  always_comb begin
    w_st_be    = 4'b0000;
    w_st_wdata = 32'h0;
    unique case (w_size)
      2'b00: begin
        w_st_be    = 4'b0001 << d_addr[1:0];
        w_st_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        w_st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        w_st_be    = 4'b1111;
        w_st_wdata = d_wdata;
      end
      default: begin
        w_st_be    = 4'b0000;
        w_st_wdata = 32'h0;
      end
    endcase
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] r_wait_cnt;
  logic             w_waiting;

  assign w_waiting = ((r_state == StFetch) || (r_state == StData)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == WaitW'(TIMEOUT - 1));

  // Any non-waiting cycle clears the count, so it restarts on every FETCH/DATA entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_waiting) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
      r_instr <= 32'h00000013;
      r_rdata <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      unique case (r_state)
        StFetch: begin
          if (mem_ready) begin
            r_instr <= mem_rdata;
            r_state <= StExec;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_state <= StHalt;
          end
        end
        StExec: begin
          if (!w_is_mem) begin
            r_state <= StFetch;
          end else if (w_misalign) begin
            r_fault <= 1'b1;
            r_state <= StHalt;
          end else begin
            r_state <= StData;
          end
        end
        StData: begin
          if (mem_ready) begin
            if (w_is_load) begin
              r_rdata <= mem_rdata;
            end
            r_state <= StWb;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_state <= StHalt;
          end
        end
        StWb:    r_state <= StFetch;
        StHalt:  r_state <= StHalt;
        default: r_state <= StHalt;
      endcase
    end
  end

  // Memory and step outputs decode the registered state; reset gates them off immediately.
  always_comb begin
    step      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (!reset) begin
      unique case (r_state)
        StFetch: begin
          mem_req  = 1'b1;
          mem_addr = {pc[31:2], 2'b00};
        end
        StExec: begin
          step = !w_is_mem;
        end
        StData: begin
          mem_req  = 1'b1;
          mem_addr = {d_addr[31:2], 2'b00};
          if (w_is_store) begin
            mem_we    = 1'b1;
            mem_be    = w_st_be;
            mem_wdata = w_st_wdata;
          end
        end
        StWb: begin
          step = 1'b1;
        end
        StHalt: begin
          step = 1'b0;
        end
        default: begin
          step = 1'b0;
        end
      endcase
    end
  end

  assign instr = r_instr;
  assign rdata = r_rdata;
  assign fault = r_fault;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer; the bench drives the memory side itself.
module tb_mem_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] instr;
  logic [31:0] rdata;
  logic        step;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        fault;

  int n_checks;
  int n_fail;

  mem_sequencer #(
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .instr    (instr),
    .rdata    (rdata),
    .step     (step),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven just after the falling edge; outputs sampled 1ns later.
  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", mem_req); end
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b exp 0", step); end
    n_checks++; if (instr !== 32'h00000013) begin n_fail++; $display("FAIL rst_instr: got %h exp 00000013", instr); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b exp 0", fault); end
    n_checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin
      n_fail++; $display("FAIL rst_memout: we=%b be=%b addr=%h wdata=%h exp all 0", mem_we, mem_be, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_addi_stream();
    logic [31:0] words [3];
    words = '{32'h00100093, 32'h00208113, 32'h00310193};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b0; pc = 32'(i * 4); mem_ready = 1'b1; mem_rdata = words[i]; #1;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || step !== 1'b0) begin
        n_fail++; $display("FAIL addi_fetch%0d: req=%b we=%b step=%b exp 1 0 0", i, mem_req, mem_we, step);
      end
      n_checks++; if (mem_addr !== 32'(i * 4)) begin
        n_fail++; $display("FAIL addi_addr%0d: got %h exp %h", i, mem_addr, 32'(i * 4));
      end
      @(negedge clk);
      mem_rdata = 32'hFFFFFFFF; #1;
      n_checks++; if (step !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL addi_exec%0d: step=%b req=%b we=%b exp 1 0 0", i, step, mem_req, mem_we);
      end
      n_checks++; if (instr !== words[i]) begin
        n_fail++; $display("FAIL addi_instr%0d: got %h exp %h", i, instr, words[i]);
      end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] t_word [3];
    logic [31:0] t_addr [3];
    logic [31:0] t_wd   [3];
    logic [31:0] e_addr [3];
    logic [3:0]  e_be   [3];
    logic [31:0] e_wd   [3];
    t_word = '{32'h002081A3, 32'h00209123, 32'h0020A223};
    t_addr = '{32'h00000103, 32'h00000202, 32'h00000204};
    t_wd   = '{32'h000000AB, 32'h1234ABCD, 32'hCAFEF00D};
    e_addr = '{32'h00000100, 32'h00000200, 32'h00000204};
    e_be   = '{4'b1000, 4'b1100, 4'b1111};
    e_wd   = '{32'hABABABAB, 32'hABCDABCD, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = 32'h0000000C; mem_ready = 1'b1; mem_rdata = t_word[i];
      d_addr = t_addr[i]; d_wdata = t_wd[i]; #1;
      @(negedge clk);
      mem_rdata = 32'h0; #1;
      n_checks++; if (step !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL st_exec%0d: step=%b req=%b exp 0 0", i, step, mem_req);
      end
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || step !== 1'b0) begin
        n_fail++; $display("FAIL st_data%0d: req=%b we=%b step=%b exp 1 1 0", i, mem_req, mem_we, step);
      end
      n_checks++; if (mem_addr !== e_addr[i] || mem_be !== e_be[i] || mem_wdata !== e_wd[i]) begin
        n_fail++; $display("FAIL st_lane%0d: addr=%h be=%b wdata=%h exp %h %b %h",
                           i, mem_addr, mem_be, mem_wdata, e_addr[i], e_be[i], e_wd[i]);
      end
      @(negedge clk); #1;
      n_checks++; if (step !== 1'b1 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL st_wb%0d: step=%b req=%b exp 1 0", i, step, mem_req);
      end
    end
  endtask

  task automatic test_load_wait();
    @(negedge clk);
    pc = 32'h00000010; mem_ready = 1'b1; mem_rdata = 32'h0000A283; #1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h12345678; d_addr = 32'h00000200; #1;
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL lw_exec_step: got %b exp 0", step); end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk); #1;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200 || step !== 1'b0) begin
        n_fail++; $display("FAIL lw_wait%0d: req=%b we=%b addr=%h step=%b exp 1 0 00000200 0",
                           w, mem_req, mem_we, mem_addr, step);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    n_checks++; if (mem_req !== 1'b1 || step !== 1'b0) begin
      n_fail++; $display("FAIL lw_ready: req=%b step=%b exp 1 0", mem_req, step);
    end
    @(negedge clk);
    mem_rdata = 32'h55555555; #1;
    n_checks++; if (step !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_wb: step=%b rdata=%h exp 1 deadbeef", step, rdata);
    end
    @(negedge clk);
    mem_ready = 1'b0; pc = 32'h00000014; #1;
    n_checks++; if (rdata !== 32'hDEADBEEF || step !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL lw_after: rdata=%h step=%b req=%b exp deadbeef 0 1", rdata, step, mem_req);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    pc = 32'h00000020; mem_ready = 1'b1; mem_rdata = 32'h00209023; #1;
    @(negedge clk);
    d_addr = 32'h00000201; #1;
    n_checks++; if (step !== 1'b0 || mem_req !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL mis_exec: step=%b req=%b fault=%b exp 0 0 0", step, mem_req, fault);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++; if (fault !== 1'b1 || mem_req !== 1'b0 || step !== 1'b0) begin
        n_fail++; $display("FAIL mis_halt%0d: fault=%b req=%b step=%b exp 1 0 0", c, fault, mem_req, step);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    reset = 1'b1; #1;
    @(negedge clk);
    reset = 1'b0; pc = 32'h00000030; mem_ready = 1'b1; mem_rdata = 32'h0020A023; #1;
    n_checks++; if (fault !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rs_clear: fault=%b req=%b exp 0 1", fault, mem_req);
    end
    @(negedge clk);
    mem_ready = 1'b0; d_addr = 32'h00000300; d_wdata = 32'h11223344; #1;
    @(negedge clk); #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rs_wait1: req=%b we=%b exp 1 1", mem_req, mem_we);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || instr !== 32'h00000013 || step !== 1'b0) begin
      n_fail++; $display("FAIL rs_mid: req=%b we=%b instr=%h step=%b exp 0 0 00000013 0",
                         mem_req, mem_we, instr, step);
    end
    @(negedge clk);
    reset = 1'b0; pc = 32'h00000042; #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h00000040) begin
      n_fail++; $display("FAIL rs_refetch: req=%b we=%b addr=%h exp 1 0 00000040", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_timeout();
    bit bad;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; #1;
    @(negedge clk);
    reset = 1'b0; pc = 32'h00000080; #1;
`ifdef MEM_SEQ_TIMEOUT_EN
    bad = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        @(negedge clk); #1;
      end
      if (mem_req !== 1'b1 || fault !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL to_wait: got early fault or dropped req, exp req held 16 cycles"); end
    @(negedge clk); #1;
    n_checks++; if (fault !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL to_fault: fault=%b req=%b exp 1 0", fault, mem_req);
    end
`else
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (mem_req !== 1'b1 || fault !== 1'b0 || mem_addr !== 32'h00000080) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL nto_hold: req=%b fault=%b exp req held 1, fault 0", mem_req, fault); end
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    pc        = 32'h0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    test_reset();
    test_addi_stream();
    test_store_lanes();
    test_load_wait();
    test_misaligned();
    test_reset_mid_store();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle sequencer that lets the RV32 datapath run against one shared single-port memory. It fetches each instruction into a held instruction register and decodes the latched opcode. For loads and stores it runs a second memory access using the datapath's address and write data. It then asserts a one-cycle `step` strobe that gates the PC register and register-file write in the datapath.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum wait cycles per memory access before fault. Used only with the macro.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pc`  in  32  datapath PC, used as fetch address
- `d_addr`  in  32  datapath `Mem_WrAddr` (ALU result)
- `d_wdata`  in  32  datapath `Mem_WrData`
- `instr`  out  32  latched instruction, driven to the datapath `Instr`
- `rdata`  out  32  latched load word, driven to the datapath `ReadData`
- `step`  out  1  one-cycle commit strobe: PC and register-file write enable
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write when 1
- `mem_addr`  out  32  word address; bits [1:0] are forced to 0
- `mem_be`  out  4  byte enables, meaningful only when `mem_we`=1
- `mem_wdata`  out  32  write data, lane-replicated
- `mem_rdata`  in  32  read data, valid in the cycle `mem_ready`=1
- `mem_ready`  in  1  access completes in this cycle
- `fault`  out  1  sticky error flag; the core is halted while it is set

## Operation
- States: FETCH, EXEC, DATA, WB, HALT.
- FETCH:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={pc[31:2],2'b00}.
  - On `mem_ready`: `instr`<=`mem_rdata`, go to EXEC.
- EXEC: decode `instr[6:0]`.
  - 0000011 (load) or 0100011 (store): go to DATA. `step` stays 0.
  - Any other opcode: `step`=1, go to FETCH.
- DATA:
  - `mem_req`=1, `mem_addr`={d_addr[31:2],2'b00}, `mem_we`=1 for stores.
  - Store encoding by `instr[13:12]` (funct3 low bits):
    - 00 (byte): `mem_be`=4'b0001<<d_addr[1:0], `mem_wdata`={4{d_wdata[7:0]}}
    - 01 (half): `mem_be`=4'b0011<<{d_addr[1],1'b0}, `mem_wdata`={2{d_wdata[15:0]}}
    - 10 (word): `mem_be`=4'b1111, `mem_wdata`=`d_wdata`
  - On `mem_ready`: for a load, `rdata`<=`mem_rdata` (raw word; no extension or shifting here). Go to WB.
- WB: `step`=1, go to FETCH.
- Misalignment: half access with `d_addr[0]`=1, word access with `d_addr[1:0]`≠0, or funct3[1:0]=11.
  - Checked in EXEC. No access is issued.
  - `fault`<=1, go to HALT.
- HALT: `mem_req`=0, `step`=0. Only `reset` leaves HALT.
- Inputs `pc`, `d_addr` and `d_wdata` are stable from EXEC through DATA, because the datapath does not update before `step`.

## Timing
- Reset (async):
  - state=FETCH, `instr`=32'h00000013 (NOP), `rdata`=0, `fault`=0.
  - `step`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0 while `reset` is high.
  - The first fetch is requested in the first cycle after `reset` falls.
- `mem_req` and all `mem_*` outputs are held stable until the cycle in which `mem_ready`=1.
- `mem_ready` with `mem_req`=0 is ignored.
- With zero-wait memory (`mem_ready` in the request cycle):
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load or store: 4 cycles (FETCH, EXEC, DATA, WB).
- Each wait cycle adds 1 cycle to the access it occurs in.
- `step` is registered-state decoded, is high for exactly 1 cycle per instruction, and is never high in FETCH or DATA.
- Reset mid-access drops `mem_req` immediately. A write in progress may be lost; the memory tolerates this.

## Configuration
- Macro `MEM_SEQ_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to FETCH or DATA and increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - When the count reaches `TIMEOUT` with no `mem_ready`: `fault`<=1, `mem_req` drops the next cycle, go to HALT.
- Undefined: no counter; the block waits indefinitely for `mem_ready`.

## Test plan
- Zero-wait ADDI stream, pc 0,4,8 → `step` pulses every 2nd cycle; `instr` matches each memory word; `mem_we`=0 throughout.
- SB, `d_addr`=0x103, `d_wdata`=0xAB → DATA drives `mem_addr`=0x100, `mem_be`=4'b1000, `mem_wdata`=0xABABABAB, `mem_we`=1; `step` in the WB cycle; 4 cycles total.
- LW, `d_addr`=0x200, `mem_ready` delayed 3 cycles → `rdata`=`mem_rdata` latched; instruction takes 7 cycles; request signals constant while waiting.
- SH with `d_addr`=0x201 → no DATA request, `fault`=1 one cycle after EXEC, HALT; `step` stays 0 until `reset`.
- Assert `reset` in the 2nd wait cycle of a store → `mem_req`=0 immediately, `instr`=0x00000013; after release the fetch is reissued from `pc`.
- `MEM_SEQ_TIMEOUT_EN` defined with `TIMEOUT`=16 and `mem_ready` tied low → `fault` rises after the 16th waiting cycle, then `mem_req`=0. Macro undefined → `mem_req` held with no fault after 100 cycles.
